// File: rtl/bounce_counter_pkg.sv
// bounce_counter_pkg: count modes and direction constants shared by the counter and its bench
package bounce_counter_pkg;
  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/bounce_counter.sv
// bounce_counter: up/down/ping-pong counter with run-time bounds; BOUNCE_TURN_CNT_EN adds a saturating reversal counter
module bounce_counter
  import bounce_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0,
  parameter int TURN_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [WIDTH-1:0]  i_lo,
  input  logic [WIDTH-1:0]  i_hi,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_dir,
  output logic              o_at_lo,
  output logic              o_at_hi,
  output logic              o_wrap,
  output logic              o_turn,
  output logic              o_cfg_err,
  output logic [TURN_W-1:0] o_turn_cnt
);
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_dir, w_dir_nxt, r_wrap, w_wrap_nxt, r_turn, w_turn_nxt;
  logic             w_cfg_err, w_in_range;
  mode_e            w_mode;
  assign w_mode     = mode_e'(i_mode);
  assign w_cfg_err  = i_hi <= i_lo;
  assign w_in_range = r_count >= i_lo && r_count <= i_hi;
  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;
    w_turn_nxt  = 1'b0;
    if (w_cfg_err) begin
      w_count_nxt = i_lo;
      w_dir_nxt   = DIR_UP;
    end else if (i_load) begin
      w_count_nxt = (i_load_val >= i_lo && i_load_val <= i_hi) ? i_load_val : i_lo;
      // loading onto an endpoint points dir away from it so the next step stays in range
      if (w_mode == MODE_BOUNCE)
        w_dir_nxt = (w_count_nxt == i_hi) ? DIR_DOWN : (w_count_nxt == i_lo) ? DIR_UP : r_dir;
    end else if (i_en) begin
      case (w_mode)
        MODE_UP: begin
          w_count_nxt = (r_count < i_hi) ? r_count + 1'b1 : i_lo;
          w_wrap_nxt  = r_count >= i_hi;
        end
        MODE_DOWN: begin
          w_count_nxt = (r_count > i_lo) ? r_count - 1'b1 : i_hi;
          w_wrap_nxt  = r_count <= i_lo;
        end
        MODE_BOUNCE: begin
          if (!w_in_range) begin
            w_count_nxt = i_lo;
            w_dir_nxt   = DIR_UP;
          end else if (r_dir == DIR_UP) begin
            w_count_nxt = (r_count < i_hi) ? r_count + 1'b1 : i_hi - 1'b1;
            w_turn_nxt  = r_count == i_hi;
            w_dir_nxt   = w_turn_nxt ? DIR_DOWN : DIR_UP;
          end else begin
            w_count_nxt = (r_count > i_lo) ? r_count - 1'b1 : i_lo + 1'b1;
            w_turn_nxt  = r_count == i_lo;
            w_dir_nxt   = w_turn_nxt ? DIR_UP : DIR_DOWN;
          end
        end
        default: w_count_nxt = r_count;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= WIDTH'(RST_VAL);
      r_dir   <= DIR_UP;
      r_wrap  <= 1'b0;
      r_turn  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_wrap  <= w_wrap_nxt;
      r_turn  <= w_turn_nxt;
    end
  end
`ifdef BOUNCE_TURN_CNT_EN
  logic [TURN_W-1:0] r_turn_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_turn_cnt <= '0;
    else if (i_load)
      r_turn_cnt <= '0;
    else if (w_turn_nxt && !(&r_turn_cnt))
      r_turn_cnt <= r_turn_cnt + 1'b1;
  end
  assign o_turn_cnt = r_turn_cnt;
`else
  assign o_turn_cnt = '0;
`endif
  assign o_count   = r_count;
  assign o_dir     = r_dir;
  assign o_wrap    = r_wrap;
  assign o_turn    = r_turn;
  assign o_cfg_err = w_cfg_err;
  assign o_at_lo   = r_count == i_lo;
  assign o_at_hi   = r_count == i_hi;
endmodule
